// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - registered ALU with shared shift-add multiply / restoring divide engine.
// Optional ALU_OVERFLOW_EN adds the ovf output for signed ADD/SUB overflow.
module alu_iter #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ALUC,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
`ifdef ALU_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             illegal
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_NOR  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MULU = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;

  typedef enum logic {S_IDLE, S_ITER} state_t;

  state_t state_q, state_d;

  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [SHW-1:0]   count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic             done_q, done_d;
`ifdef ALU_OVERFLOW_EN
  logic             ovf_q, ovf_d;
  logic             sc_ovf;
`endif

  logic             is_iter;
  logic             last;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] add_sum;
  logic [WIDTH-1:0] sub_diff;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ill;

  logic [WIDTH:0]   eng_x;
  logic [WIDTH:0]   eng_y;
  logic             eng_cin;
  logic [WIDTH+1:0] eng_sum;
  logic             q_bit;
  logic [WIDTH-1:0] hi_nx;
  logic [WIDTH-1:0] lo_nx;

  assign is_iter  = (ALUC == OP_MULU) || (ALUC == OP_DIVU);
  assign last     = (count_q == SHW'(WIDTH - 1));
  assign shamt    = B[SHW-1:0];
  assign add_sum  = A + B;
  assign sub_diff = A - B;

  always_comb begin
    sc_res = '0;
    sc_ill = 1'b0;
    case (ALUC)
      OP_ADD:  sc_res = add_sum;
      OP_SUB:  sc_res = sub_diff;
      OP_AND:  sc_res = A & B;
      OP_OR:   sc_res = A | B;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_XOR:  sc_res = A ^ B;
      OP_NOR:  sc_res = ~(A | B);
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLL:  sc_res = A << shamt;
      OP_SRL:  sc_res = A >> shamt;
      OP_SRA:  sc_res = WIDTH'($signed(A) >>> shamt);
      OP_MULU: sc_res = '0;
      OP_DIVU: sc_res = '0;
      default: sc_ill = 1'b1;
    endcase
  end

`ifdef ALU_OVERFLOW_EN
  always_comb begin
    sc_ovf = 1'b0;
    if (ALUC == OP_ADD)
      sc_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
    else if (ALUC == OP_SUB)
      sc_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (sub_diff[WIDTH-1] != A[WIDTH-1]);
  end
`endif

  // One adder serves both engines: MUL adds the multiplicand into the high
  // word; DIV subtracts the divisor from the shifted partial remainder and
  // uses the carry-out as the "no borrow" quotient bit.
  always_comb begin
    if (is_div_q) begin
      eng_x   = {hi_q, lo_q[WIDTH-1]};
      eng_y   = ~{1'b0, a_q};
      eng_cin = 1'b1;
    end else begin
      eng_x   = {1'b0, hi_q};
      eng_y   = lo_q[0] ? {1'b0, a_q} : '0;
      eng_cin = 1'b0;
    end
    eng_sum = {1'b0, eng_x} + {1'b0, eng_y} + (WIDTH+2)'(eng_cin);
  end

  always_comb begin
    q_bit = eng_sum[WIDTH+1];
    if (is_div_q) begin
      hi_nx = q_bit ? eng_sum[WIDTH-1:0] : {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
      lo_nx = {lo_q[WIDTH-2:0], q_bit};
    end else begin
      hi_nx = eng_sum[WIDTH:1];
      lo_nx = {eng_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start && is_iter) state_d = S_ITER;
      S_ITER: if (last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == S_ITER);
    done      = done_q;
    result    = result_q;
    result_hi = result_hi_q;
    zero      = zero_q;
    illegal   = illegal_q;
`ifdef ALU_OVERFLOW_EN
    ovf       = ovf_q;
`endif
  end

  always_comb begin
    is_div_d    = is_div_q;
    a_d         = a_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    count_d     = count_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    done_d      = 1'b0;
`ifdef ALU_OVERFLOW_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_iter) begin
            is_div_d = (ALUC == OP_DIVU);
            a_d      = (ALUC == OP_DIVU) ? B : A;
            lo_d     = (ALUC == OP_DIVU) ? A : B;
            hi_d     = '0;
            count_d  = '0;
          end else begin
            result_d    = sc_res;
            result_hi_d = '0;
            zero_d      = (sc_res == '0);
            illegal_d   = sc_ill;
            done_d      = 1'b1;
`ifdef ALU_OVERFLOW_EN
            ovf_d       = sc_ovf;
`endif
          end
        end
      end
      S_ITER: begin
        hi_d    = hi_nx;
        lo_d    = lo_nx;
        count_d = count_q + SHW'(1);
        if (last) begin
          result_d    = lo_nx;
          result_hi_d = hi_nx;
          zero_d      = (lo_nx == '0);
          illegal_d   = 1'b0;
          done_d      = 1'b1;
`ifdef ALU_OVERFLOW_EN
          ovf_d       = 1'b0;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_div_q    <= 1'b0;
      a_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      count_q     <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      done_q      <= 1'b0;
`ifdef ALU_OVERFLOW_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      is_div_q    <= is_div_d;
      a_q         <= a_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      count_q     <= count_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      done_q      <= done_d;
`ifdef ALU_OVERFLOW_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// tb/tb_alu_iter.sv - scoreboard bench for alu_iter with a behavioural reference model.
module tb_alu_iter;

  localparam int W   = 32;
  localparam int SHW = $clog2(W);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   aluc = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, zero, illegal;
  logic [W-1:0] result, result_hi;
`ifdef ALU_OVERFLOW_EN
  logic         ovf;
`endif

  alu_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ALUC(aluc), .A(a), .B(b),
    .busy(busy), .done(done), .result(result), .result_hi(result_hi),
    .zero(zero),
`ifdef ALU_OVERFLOW_EN
    .ovf(ovf),
`endif
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] r;
    logic [W-1:0] rh;
    logic         z;
    logic         ill;
    logic         ov;
    int           due;
    logic [3:0]   op;
  } exp_t;

  exp_t         sbq[$];
  exp_t         mon_e;
  logic [W-1:0] held_r = '0;
  logic [W-1:0] held_rh = '0;
  int           n_tests = 0;
  int           n_fail = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(logic [3:0] op, logic [W-1:0] x, logic [W-1:0] y);
    exp_t               e;
    logic [2*W-1:0]     p;
    logic signed [W:0]  s;
    int                 sh;
    e.r = '0; e.rh = '0; e.ill = 1'b0; e.ov = 1'b0; e.due = 0; e.op = op;
    sh = int'(y[SHW-1:0]);
    case (op)
      4'd0: begin
        e.r = x + y;
        s = $signed({x[W-1], x}) + $signed({y[W-1], y});
        e.ov = s[W] ^ s[W-1];
      end
      4'd1: begin
        e.r = x - y;
        s = $signed({x[W-1], x}) - $signed({y[W-1], y});
        e.ov = s[W] ^ s[W-1];
      end
      4'd2:  e.r = x & y;
      4'd3:  e.r = x | y;
      4'd4:  e.r = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      4'd5:  e.r = x ^ y;
      4'd6:  e.r = ~(x | y);
      4'd7:  e.r = (x < y) ? W'(1) : W'(0);
      4'd8:  e.r = x << sh;
      4'd9:  e.r = x >> sh;
      4'd10: e.r = W'($signed(x) >>> sh);
      4'd12: begin
        p = (2*W)'(x) * (2*W)'(y);
        e.r = p[W-1:0];
        e.rh = p[2*W-1:W];
      end
      4'd13: begin
        if (y == '0) begin
          e.r = '1;
          e.rh = x;
        end else begin
          e.r = x / y;
          e.rh = x % y;
        end
      end
      default: e.ill = 1'b1;
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  task automatic issue(logic [3:0] op, logic [W-1:0] x, logic [W-1:0] y);
    exp_t e;
    int   guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL busy_timeout: busy still 1, expected 0 within 100 cycles");
      start = 1'b0;
    end else begin
      e = model(op, x, y);
      e.due = cyc + 1 + ((op == 4'd12 || op == 4'd13) ? W : 0);
      sbq.push_back(e);
      start = 1'b1;
      aluc = op;
      a = x;
      b = y;
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return W'($urandom_range(0, 40));
      3:       return {1'b1, (W-1)'($urandom)};
      default: return W'($urandom);
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (sbq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: done=1 with no op outstanding (cycle %0d)", cyc);
        end else begin
          mon_e = sbq.pop_front();
          check($sformatf("result op%0d", mon_e.op), 64'(result), 64'(mon_e.r));
          check($sformatf("result_hi op%0d", mon_e.op), 64'(result_hi), 64'(mon_e.rh));
          check($sformatf("zero op%0d", mon_e.op), 64'(zero), 64'(mon_e.z));
          check($sformatf("illegal op%0d", mon_e.op), 64'(illegal), 64'(mon_e.ill));
          check($sformatf("latency op%0d", mon_e.op), 64'(cyc), 64'(mon_e.due));
`ifdef ALU_OVERFLOW_EN
          check($sformatf("ovf op%0d", mon_e.op), 64'(ovf), 64'(mon_e.ov));
`endif
        end
        held_r  = result;
        held_rh = result_hi;
      end else if (busy) begin
        check("hold_during_iter", {result_hi, result}, {held_rh, held_r});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", {busy, done, zero, illegal, result, result_hi},
          {4'b0000, {(2*W){1'b0}}});
    rst_n = 1'b1;

    issue(4'd1, 32'h0000_0001, 32'hFFFF_FFFF);
    issue(4'd4, 32'h0000_0001, 32'hFFFF_FFFF);
    issue(4'd7, 32'h0000_0001, 32'hFFFF_FFFF);
    issue(4'd10, 32'h8000_0000, 32'h0000_0024);
    issue(4'd9, 32'h8000_0000, 32'h0000_0024);
    issue(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(5);
    @(negedge clk);
    start = 1'b1; aluc = 4'd0; a = 32'd5; b = 32'd6;
    idle(1);
    issue(4'd13, 32'd100, 32'd7);
    issue(4'd0, 32'd3, 32'd4);
    issue(4'd13, 32'h0000_1234, 32'h0000_0000);
    issue(4'd15, 32'h1234_5678, 32'h0000_0001);
    issue(4'd0, 32'h7FFF_FFFF, 32'h0000_0001);
    issue(4'd11, 32'h0, 32'h0);
    issue(4'd1, 32'h8000_0000, 32'h0000_0001);
    issue(4'd0, 32'h0, 32'h0);
    idle(3);

    issue(4'd12, 32'hDEAD_BEEF, 32'h1234_5678);
    idle(11);
    sbq.delete();
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_mid_mulu", {busy, done, result, result_hi}, {2'b00, {(2*W){1'b0}}});
    held_r = '0;
    held_rh = '0;
    rst_n = 1'b1;
    idle(40);

    for (int i = 0; i < 150; i++)
      issue(4'($urandom_range(0, 15)), rand_operand(), rand_operand());
    idle(1);
    for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 64'(sbq.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
